mac_reg_bank: RTL and testbench



---
 rtl/mac_reg_bank.sv | 243 ++++++++++++++++++++++++
 tb/tb_mac_reg_bank.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : mac_reg_bank
// Summary  : Host CSR bank for the tri-mode MAC. Holds control/pulse registers,
//            a W1C sticky status with interrupt, and an RMON counter fetch engine.
// Revision : 1.0 - initial release
// ============================================================================
module mac_reg_bank #(
  parameter int                 DW         = 16,
  parameter int                 AW         = 8,
  parameter int                 NREG       = 35,
  parameter logic [NREG*DW-1:0] INIT       = '0,
  parameter logic [NREG-1:0]    PULSE_MASK = '0,
  parameter int                 NSTS       = 8,
  parameter int                 TMO_CYC    = 1024
) (
  input  logic                 Clk_reg,
  input  logic                 Reset,
  input  logic                 CSB,
  input  logic                 WRB,
  input  logic [AW-1:0]        CA,
  input  logic [DW-1:0]        CD_in,
  output logic [DW-1:0]        CD_out,
  output logic                 CD_out_vld,
  output logic [NREG*DW-1:0]   reg_q,
  input  logic [NSTS-1:0]      sts_in,
  output logic                 irq,
  output logic [5:0]           CPU_rd_addr,
  output logic                 CPU_rd_apply,
  input  logic                 CPU_rd_grant,
  input  logic [31:0]          CPU_rd_dout
);

  localparam int IW = AW - 1;
  localparam int CW = $clog2(TMO_CYC);

  localparam logic [IW-1:0] C_IDX_STS   = IW'(NREG);
  localparam logic [IW-1:0] C_IDX_MASK  = IW'(NREG + 1);
  localparam logic [IW-1:0] C_IDX_CMD   = IW'(NREG + 2);
  localparam logic [IW-1:0] C_IDX_RSTAT = IW'(NREG + 3);
  localparam logic [IW-1:0] C_IDX_DLO   = IW'(NREG + 4);
  localparam logic [IW-1:0] C_IDX_DHI   = IW'(NREG + 5);
  localparam logic [CW-1:0] C_CNT_LAST  = CW'(TMO_CYC - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } rmon_state_e;

  logic [IW-1:0]   w_idx;
  logic            w_wr_acc;
  logic            w_rd;
  logic            w_wr_p;
  logic            wr_acc_q;
  logic            unused_ca0;

  assign w_idx      = CA[AW-1:1];
  assign unused_ca0 = CA[0];
  assign w_wr_acc   = !CSB && !WRB;
  assign w_rd       = !CSB && WRB;
  // A held write strobe only acts on its first cycle.
  assign w_wr_p     = w_wr_acc && !wr_acc_q;

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NREG; i++) begin : g_ctl
    localparam logic [DW-1:0] C_INIT_I = INIT[i*DW +: DW];
    logic [DW-1:0] ctl_q;
    logic [DW-1:0] ctl_d;

    always_comb begin
      ctl_d = ctl_q;
      if (w_wr_p && (w_idx == IW'(i))) begin
        ctl_d = CD_in;
      end else if (PULSE_MASK[i]) begin
        ctl_d = C_INIT_I;
      end
    end

    always_ff @(posedge Clk_reg) begin
      if (Reset) begin
        ctl_q <= C_INIT_I;
      end else begin
        ctl_q <= ctl_d;
      end
    end

    assign reg_q[i*DW +: DW] = ctl_q;
  end

  // --------------------------------------------------------------------------
  // Sticky status, interrupt mask
  // --------------------------------------------------------------------------
  logic [NSTS-1:0] sticky_q;
  logic [NSTS-1:0] sticky_d;
  logic [NSTS-1:0] w_w1c;
  logic [DW-1:0]   mask_q;
  logic [DW-1:0]   mask_d;
  logic            irq_q;

  always_comb begin
    w_w1c  = '0;
    mask_d = mask_q;
    if (w_wr_p && (w_idx == C_IDX_STS)) begin
      w_w1c = CD_in[NSTS-1:0];
    end
    if (w_wr_p && (w_idx == C_IDX_MASK)) begin
      mask_d = CD_in;
    end
    // OR-ing the new events last lets a set beat a concurrent clear.
    sticky_d = (sticky_q & ~w_w1c) | sts_in;
  end

  // --------------------------------------------------------------------------
  // RMON fetch engine
  // --------------------------------------------------------------------------
  rmon_state_e   state_q, state_d;
  logic [5:0]    addr_q, addr_d;
  logic          apply_q, apply_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tmo_q, tmo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   data_q, data_d;

  always_ff @(posedge Clk_reg) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      apply_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      apply_q <= apply_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    apply_d = apply_q;
    busy_d  = busy_q;
    done_d  = done_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (w_wr_p && (w_idx == C_IDX_CMD)) begin
          state_d = ST_REQ;
          addr_d  = CD_in[5:0];
          apply_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          tmo_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_REQ: begin
        // Grant is checked first so a grant on the last allowed cycle still captures.
        if (CPU_rd_grant) begin
          data_d  = CPU_rd_dout;
          apply_d = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (cnt_q == C_CNT_LAST) begin
          apply_d = 1'b0;
          tmo_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Read mux and registered host-side outputs
  // --------------------------------------------------------------------------
  logic [DW-1:0] w_rdata;
  logic [DW-1:0] cd_out_q;
  logic          cd_vld_q;

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NREG; i++) begin
      if (w_idx == IW'(i)) begin
        w_rdata = reg_q[i*DW +: DW];
      end
    end
    case (w_idx)
      C_IDX_STS:   w_rdata = DW'(sticky_q);
      C_IDX_MASK:  w_rdata = mask_q;
      C_IDX_CMD:   w_rdata = DW'(addr_q);
      C_IDX_RSTAT: w_rdata = DW'({tmo_q, done_q, busy_q});
      C_IDX_DLO:   w_rdata = DW'(data_q[15:0]);
      C_IDX_DHI:   w_rdata = DW'(data_q[31:16]);
      default:     ;
    endcase
  end

  always_ff @(posedge Clk_reg) begin
    if (Reset) begin
      wr_acc_q <= 1'b0;
      sticky_q <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
      cd_out_q <= '0;
      cd_vld_q <= 1'b0;
    end else begin
      wr_acc_q <= w_wr_acc;
      sticky_q <= sticky_d;
      mask_q   <= mask_d;
      irq_q    <= |(sticky_q & mask_q[NSTS-1:0]);
      cd_out_q <= w_rd ? w_rdata : '0;
      cd_vld_q <= w_rd;
    end
  end

  assign CD_out       = cd_out_q;
  assign CD_out_vld   = cd_vld_q;
  assign irq          = irq_q;
  assign CPU_rd_addr  = addr_q;
  assign CPU_rd_apply = apply_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_reg_bank
// Summary  : Self-checking bench for mac_reg_bank against a register-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_reg_bank;
  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int NREG = 35;
  localparam int NSTS = 8;
  localparam int TMO  = 40;
  localparam logic [NREG*DW-1:0] INIT_V =
    ((NREG*DW)'(16'h2710) << (26*DW)) | (NREG*DW)'(16'h0009);
  localparam logic [NREG-1:0] PULSE_V = NREG'(1) << 10;
  localparam int IDX_STS   = NREG;
  localparam int IDX_MASK  = NREG + 1;
  localparam int IDX_CMD   = NREG + 2;
  localparam int IDX_RSTAT = NREG + 3;
  localparam int IDX_DLO   = NREG + 4;
  localparam int IDX_DHI   = NREG + 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              csb, wrb;
  logic [AW-1:0]     ca;
  logic [DW-1:0]     cd_in, cd_out;
  logic              cd_vld;
  logic [NREG*DW-1:0] regs;
  logic [NSTS-1:0]   sts;
  logic              irq;
  logic [5:0]        rd_addr;
  logic              rd_apply, rd_grant;
  logic [31:0]       rd_dout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: the register map as the host sees it.
  logic [DW-1:0]   m_ctl [NREG];
  logic [NSTS-1:0] m_sticky;
  logic [DW-1:0]   m_mask;
  logic [5:0]      m_addr;
  logic [2:0]      m_stat;   // {timeout, done, busy}
  logic [31:0]     m_data;

  always #5 clk = ~clk;

  mac_reg_bank #(
    .DW(DW), .AW(AW), .NREG(NREG), .INIT(INIT_V), .PULSE_MASK(PULSE_V),
    .NSTS(NSTS), .TMO_CYC(TMO)
  ) dut (
    .Clk_reg(clk), .Reset(rst), .CSB(csb), .WRB(wrb), .CA(ca), .CD_in(cd_in),
    .CD_out(cd_out), .CD_out_vld(cd_vld), .reg_q(regs), .sts_in(sts), .irq(irq),
    .CPU_rd_addr(rd_addr), .CPU_rd_apply(rd_apply), .CPU_rd_grant(rd_grant),
    .CPU_rd_dout(rd_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    csb   = 1'b1;
    wrb   = 1'b1;
    ca    = AW'($urandom);
    cd_in = DW'($urandom);
  endtask

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) m_ctl[i] = INIT_V[i*DW +: DW];
    m_sticky = '0;
    m_mask   = '0;
    m_addr   = '0;
    m_stat   = '0;
    m_data   = '0;
  endtask

  function automatic logic [DW-1:0] m_read(input int w);
    if (w < NREG) return m_ctl[w];
    case (w)
      IDX_STS:   return DW'(m_sticky);
      IDX_MASK:  return m_mask;
      IDX_CMD:   return DW'(m_addr);
      IDX_RSTAT: return DW'(m_stat);
      IDX_DLO:   return m_data[15:0];
      IDX_DHI:   return m_data[31:16];
      default:   return '0;
    endcase
  endfunction

  function automatic logic m_irq();
    return |(m_sticky & m_mask[NSTS-1:0]);
  endfunction

  function automatic logic [NREG*DW-1:0] m_regs();
    logic [NREG*DW-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) v[i*DW +: DW] = m_ctl[i];
    return v;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int w);
    logic [AW-2:0] wi;
    wi = (AW-1)'(w);
    return {wi, 1'($urandom)};
  endfunction

  // Write access held for 'hold' cycles; data changes after the first cycle.
  task automatic do_write(input int w, input logic [DW-1:0] d, input int hold);
    csb = 1'b0; wrb = 1'b0; ca = addr_of(w); cd_in = d;
    tick();
    for (int k = 1; k < hold; k++) begin
      cd_in = DW'($urandom);
      tick();
    end
    bus_idle();
    tick();
    if (w < NREG)           m_ctl[w] = PULSE_V[w] ? INIT_V[w*DW +: DW] : d;
    else if (w == IDX_STS)  m_sticky = m_sticky & ~d[NSTS-1:0];
    else if (w == IDX_MASK) m_mask = d;
  endtask

  task automatic do_read(input int w, input string nm);
    logic [DW-1:0] expv;
    expv = m_read(w);
    csb = 1'b0; wrb = 1'b1; ca = addr_of(w);
    tick();
    n_cmp++;
    if (cd_vld !== 1'b1 || cd_out !== expv) begin
      n_err++;
      $display("FAIL %s w=%0d: got vld=%b data=%h, want vld=1 data=%h", nm, w, cd_vld, cd_out, expv);
    end
    bus_idle();
    tick();
    n_cmp++;
    if (cd_vld !== 1'b0 || cd_out !== '0) begin
      n_err++;
      $display("FAIL %s_idle: got vld=%b data=%h, want vld=0 data=0", nm, cd_vld, cd_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_idle();
    repeat (3) tick();
    rst = 1'b0;
    m_reset();
    n_cmp++;
    if (regs[0 +: DW] !== 16'h0009 || regs[26*DW +: DW] !== 16'h2710) begin
      n_err++;
      $display("FAIL reset_init: got r0=%h r26=%h, want 0009/2710", regs[0 +: DW], regs[26*DW +: DW]);
    end
    n_cmp++;
    if (regs !== INIT_V) begin
      n_err++;
      $display("FAIL reset_regs: got %h, want %h", regs, INIT_V);
    end
    n_cmp++;
    if (cd_out !== '0 || cd_vld !== 1'b0 || irq !== 1'b0 || rd_apply !== 1'b0 || rd_addr !== '0) begin
      n_err++;
      $display("FAIL reset_outs: got cd=%h vld=%b irq=%b apply=%b addr=%h, want all 0",
               cd_out, cd_vld, irq, rd_apply, rd_addr);
    end
    for (int w = IDX_STS; w <= IDX_DHI; w++) do_read(w, "reset_rd");
  endtask

  task automatic test_ctrl_write();
    csb = 1'b0; wrb = 1'b0; ca = addr_of(3); cd_in = 16'h1234;
    tick();
    n_cmp++;
    if (regs[3*DW +: DW] !== 16'h1234) begin
      n_err++;
      $display("FAIL ctrl_latency: got %h, want 1234", regs[3*DW +: DW]);
    end
    for (int k = 0; k < 4; k++) begin
      cd_in = 16'h1234 ^ DW'($urandom_range(1, 65535));
      tick();
    end
    n_cmp++;
    if (regs[3*DW +: DW] !== 16'h1234) begin
      n_err++;
      $display("FAIL ctrl_once: got %h, want 1234", regs[3*DW +: DW]);
    end
    bus_idle();
    tick();
    m_ctl[3] = 16'h1234;
    do_read(3, "ctrl_rd");
    for (int n = 0; n < 24; n++) begin
      int w;
      w = $urandom_range(0, 127);
      if (w == IDX_CMD) w = 0;
      do_write(w, DW'($urandom), $urandom_range(1, 4));
      n_cmp++;
      if (regs !== m_regs() || irq !== m_irq()) begin
        n_err++;
        $display("FAIL ctrl_rand w=%0d: got irq=%b regs=%h, want irq=%b regs=%h", w, irq, regs, m_irq(), m_regs());
      end
    end
    for (int n = 0; n < 12; n++) do_read($urandom_range(0, 127) == IDX_CMD ? 1 : $urandom_range(0, NREG + 1), "ctrl_rand_rd");
  endtask

  task automatic test_pulse();
    csb = 1'b0; wrb = 1'b0; ca = addr_of(10); cd_in = 16'h0001;
    tick();
    n_cmp++;
    if (regs[10*DW +: DW] !== 16'h0001) begin
      n_err++;
      $display("FAIL pulse_high: got %h, want 0001", regs[10*DW +: DW]);
    end
    tick();
    n_cmp++;
    if (regs[10*DW +: DW] !== INIT_V[10*DW +: DW]) begin
      n_err++;
      $display("FAIL pulse_clear: got %h, want %h", regs[10*DW +: DW], INIT_V[10*DW +: DW]);
    end
    tick();
    n_cmp++;
    if (regs[10*DW +: DW] !== INIT_V[10*DW +: DW]) begin
      n_err++;
      $display("FAIL pulse_hold: got %h, want %h", regs[10*DW +: DW], INIT_V[10*DW +: DW]);
    end
    bus_idle();
    tick();
  endtask

  task automatic test_sticky();
    do_write(IDX_MASK, 16'h0004, 1);
    sts = 8'h04;
    tick();
    sts = '0;
    m_sticky = m_sticky | 8'h04;
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_lag: got %b, want 0", irq);
    end
    tick();
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_set: got %b, want 1", irq);
    end
    do_read(IDX_STS, "sticky_rd");
    sts = 8'h04;
    do_write(IDX_STS, 16'h0004, 1);
    m_sticky = m_sticky | 8'h04;
    sts = '0;
    do_read(IDX_STS, "sticky_setwins");
    do_write(IDX_STS, 16'h0004, 1);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clear: got %b, want 0", irq);
    end
    for (int n = 0; n < 10; n++) begin
      logic [NSTS-1:0] v;
      v = NSTS'($urandom);
      sts = v;
      tick();
      sts = '0;
      m_sticky = m_sticky | v;
      do_write(IDX_MASK, DW'($urandom), 1);
      do_write(IDX_STS, DW'($urandom), $urandom_range(1, 3));
      n_cmp++;
      if (irq !== m_irq()) begin
        n_err++;
        $display("FAIL irq_rand: got %b, want %b", irq, m_irq());
      end
      do_read(IDX_STS, "sticky_rand");
    end
  endtask

  // Issue one command and drive grant 'delay' cycles into the request (or never).
  task automatic run_fetch(input logic [5:0] a, input int delay, input logic give,
                           input logic [31:0] dout, input string nm);
    int cnt;
    int want;
    csb = 1'b0; wrb = 1'b0; ca = addr_of(IDX_CMD);
    cd_in = DW'($urandom);
    cd_in[5:0] = a;
    tick();
    bus_idle();
    n_cmp++;
    if (rd_apply !== 1'b1 || rd_addr !== a) begin
      n_err++;
      $display("FAIL %s_start: got apply=%b addr=%h, want apply=1 addr=%h", nm, rd_apply, rd_addr, a);
    end
    cnt = 0;
    while (rd_apply === 1'b1 && cnt < TMO + 10) begin
      rd_grant = give && (cnt == delay);
      rd_dout  = rd_grant ? dout : $urandom;
      tick();
      cnt++;
    end
    rd_grant = 1'b0;
    want = give ? delay + 1 : TMO;
    n_cmp++;
    if (cnt !== want) begin
      n_err++;
      $display("FAIL %s_apply_len: got %0d cycles, want %0d", nm, cnt, want);
    end
    m_addr = a;
    if (give) begin
      m_data = dout;
      m_stat = 3'b010;
    end else begin
      m_stat = 3'b100;
    end
    do_read(IDX_RSTAT, {nm, "_stat"});
    do_read(IDX_DLO, {nm, "_dlo"});
    do_read(IDX_DHI, {nm, "_dhi"});
    do_read(IDX_CMD, {nm, "_cmd"});
  endtask

  task automatic test_rmon_grant();
    run_fetch(6'h15, 3, 1'b1, 32'hDEADBEEF, "fetch");
    for (int n = 0; n < 4; n++)
      run_fetch(6'($urandom), $urandom_range(0, TMO - 1), 1'b1, $urandom, "fetch_rand");
  endtask

  task automatic test_rmon_timeout();
    run_fetch(6'($urandom), 0, 1'b0, 32'h0, "tmo");
    run_fetch(6'($urandom), TMO - 1, 1'b1, $urandom, "tmo_edge");
    rd_grant = 1'b1;
    rd_dout  = $urandom;
    repeat (2) tick();
    rd_grant = 1'b0;
    do_read(IDX_DLO, "idle_grant_lo");
    do_read(IDX_DHI, "idle_grant_hi");
  endtask

  task automatic test_cmd_in_req();
    csb = 1'b0; wrb = 1'b0; ca = addr_of(IDX_CMD); cd_in = 16'h002A;
    tick();
    bus_idle();
    tick();
    csb = 1'b0; wrb = 1'b0; ca = addr_of(IDX_CMD); cd_in = 16'h0011;
    tick();
    bus_idle();
    tick();
    n_cmp++;
    if (rd_addr !== 6'h2A || rd_apply !== 1'b1) begin
      n_err++;
      $display("FAIL cmd_in_req: got addr=%h apply=%b, want addr=2a apply=1", rd_addr, rd_apply);
    end
    rd_grant = 1'b1;
    rd_dout  = 32'hCAFE0123;
    tick();
    rd_grant = 1'b0;
    n_cmp++;
    if (rd_apply !== 1'b0) begin
      n_err++;
      $display("FAIL cmd_in_req_grant: got apply=%b, want 0", rd_apply);
    end
    m_addr = 6'h2A;
    m_data = 32'hCAFE0123;
    m_stat = 3'b010;
    do_read(IDX_CMD, "cmd_in_req_rd");
    do_read(IDX_DHI, "cmd_in_req_dhi");
  endtask

  task automatic test_reset_mid_req();
    csb = 1'b0; wrb = 1'b0; ca = addr_of(IDX_CMD); cd_in = 16'h0033;
    tick();
    bus_idle();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (rd_apply !== 1'b0 || rd_addr !== '0) begin
      n_err++;
      $display("FAIL reset_req: got apply=%b addr=%h, want 0/0", rd_apply, rd_addr);
    end
    rst = 1'b0;
    m_reset();
    do_read(IDX_RSTAT, "reset_req_stat");
    do_read(IDX_DLO, "reset_req_dlo");
    n_cmp++;
    if (regs !== INIT_V) begin
      n_err++;
      $display("FAIL reset_req_regs: got %h, want %h", regs, INIT_V);
    end
  endtask

  initial begin
    rst = 1'b1; csb = 1'b1; wrb = 1'b1; ca = '0; cd_in = '0;
    sts = '0; rd_grant = 1'b0; rd_dout = '0;
    m_reset();
    test_reset();
    test_ctrl_write();
    test_pulse();
    test_sticky();
    test_rmon_grant();
    test_rmon_timeout();
    test_cmd_in_req();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
